cart_download_packer: RTL



---
 rtl/cart_download_packer_if.sv | 26 ++
 rtl/cart_download_packer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cart_download_packer_if.sv
// HPS ioctl download port and SDRAM channel-2 write port
// bundled for the cartridge download packer.
interface cart_download_packer_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wr;
  logic        ioctl_wait;
  logic [26:0] sdram_addr;
  logic [31:0] sdram_din;
  logic        sdram_req;
  logic        sdram_ready;

  modport master (
    output ioctl_download, ioctl_index, ioctl_addr,
    output ioctl_dout, ioctl_wr, sdram_ready,
    input  ioctl_wait, sdram_addr, sdram_din, sdram_req
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_addr,
    input  ioctl_dout, ioctl_wr, sdram_ready,
    output ioctl_wait, sdram_addr, sdram_din, sdram_req
  );
endinterface

// File: rtl/cart_download_packer.sv
// Packs ioctl cartridge halfwords into z64-ordered 32-bit
// SDRAM writes, detecting ROM byte order from the header.
module cart_download_packer #(
  parameter int unsigned CART_START = 1048576,
  parameter logic [7:0]  CART_INDEX = 8'd1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk1x,
  input  logic        reset,
  cart_download_packer_if.slave bus,
  output logic        cart_download,
  output logic        cart_loaded,
  output logic [1:0]  rom_format,
  output logic [26:0] rom_size
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] HIWAT = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0] FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [26:0] BASE  = 27'(CART_START);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_q, state_d;

  logic [26:0]   fa_q [FIFO_DEPTH];
  logic [31:0]   fd_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d;

  logic        dl_q, act_q, sess_q, drain_q;
  logic        flush_q, pend_q, busy_q, loaded_q;
  logic        wait_q, req_q;
  logic [1:0]  fmt_q, fmt_d;
  logic [26:0] size_q, nxt_size;
  logic [15:0] h0_q;
  logic [26:2] h0a_q;
  logic [26:0] addr_q;
  logic [31:0] din_q;

  logic        dl_cart, start, fall, wr_ok;
  logic        push_w, push_f, push, pop, done;
  logic [31:0] w, pd;
  logic [26:0] wa, pa;

  assign dl_cart  = bus.ioctl_download &&
                    (bus.ioctl_index == CART_INDEX);
  assign start    = dl_cart && !act_q && !busy_q;
  assign fall     = dl_q && !bus.ioctl_download && sess_q;
  assign wr_ok    = bus.ioctl_wr && dl_cart && sess_q;
  assign push_w   = wr_ok && bus.ioctl_addr[1];
  // A trailing half-word waits for room rather than overflowing
  assign push_f   = flush_q && (cnt_q != FULL);
  assign push     = push_w || push_f;
  assign done     = drain_q && !flush_q && (cnt_q == '0) &&
                    (state_q == S_IDLE);
  assign nxt_size = bus.ioctl_addr + 27'd2;
  assign w        = push_f ? {16'h0000, h0_q}
                           : {bus.ioctl_dout, h0_q};
  assign wa       = push_f ? {h0a_q, 2'b00}
                           : {bus.ioctl_addr[26:2], 2'b00};
  assign pa       = BASE + wa;
  assign cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    fmt_d = 2'd3;
    unique case (1'b1)
      (bus.ioctl_dout == 16'h3780): fmt_d = 2'd0;
      (bus.ioctl_dout == 16'h8037): fmt_d = 2'd1;
      (bus.ioctl_dout == 16'h1240): fmt_d = 2'd2;
      default:                      fmt_d = 2'd3;
    endcase
  end

  always_comb begin
    pd = w;
    unique case (1'b1)
      (fmt_q == 2'd1): pd = {w[23:16], w[31:24],
                             w[7:0], w[15:8]};
      (fmt_q == 2'd2): pd = {w[7:0], w[15:8],
                             w[23:16], w[31:24]};
      default:         pd = w;
    endcase
  end

  // Ready with data queued re-issues at once for 1 word/ack
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: begin
        if (bus.sdram_ready) begin
          if (cnt_q != '0) pop = 1'b1;
          else state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk1x) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      dl_q     <= 1'b0;
      act_q    <= 1'b0;
      sess_q   <= 1'b0;
      drain_q  <= 1'b0;
      flush_q  <= 1'b0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
      wait_q   <= 1'b0;
      req_q    <= 1'b0;
      fmt_q    <= 2'd3;
      size_q   <= '0;
      h0_q     <= '0;
      h0a_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      dl_q    <= bus.ioctl_download;
      act_q   <= dl_cart;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= (cnt_q >= HIWAT);
      req_q   <= pop;
      if (pop) begin
        addr_q <= fa_q[rp_q];
        din_q  <= fd_q[rp_q];
        rp_q   <= rp_q + 1'b1;
      end
      if (push) begin
        fa_q[wp_q] <= pa;
        fd_q[wp_q] <= pd;
        wp_q       <= wp_q + 1'b1;
      end
      if (push_f) flush_q <= 1'b0;
      if (wr_ok) begin
        if (!bus.ioctl_addr[1]) begin
          h0_q   <= bus.ioctl_dout;
          h0a_q  <= bus.ioctl_addr[26:2];
          pend_q <= 1'b1;
        end else begin
          pend_q <= 1'b0;
        end
        if (bus.ioctl_addr == '0) fmt_q <= fmt_d;
        if (nxt_size > size_q) size_q <= nxt_size;
      end
      if (fall) begin
        sess_q  <= 1'b0;
        drain_q <= 1'b1;
        flush_q <= pend_q;
        pend_q  <= 1'b0;
      end
      if (done) begin
        busy_q   <= 1'b0;
        loaded_q <= 1'b1;
        drain_q  <= 1'b0;
      end
      if (start) begin
        sess_q   <= 1'b1;
        busy_q   <= 1'b1;
        loaded_q <= 1'b0;
        size_q   <= '0;
        fmt_q    <= 2'd3;
        wp_q     <= '0;
        rp_q     <= '0;
        cnt_q    <= '0;
        pend_q   <= 1'b0;
        flush_q  <= 1'b0;
        drain_q  <= 1'b0;
      end
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;
  assign bus.sdram_din  = din_q;
  assign cart_download  = busy_q;
  assign cart_loaded    = loaded_q;
  assign rom_format     = fmt_q;
  assign rom_size       = size_q;
endmodule
